// File: rtl/apb_sccb_cmd_regbank.sv
// APB register bank for the serial camera-configuration engine: command FIFO towards the
// engine, response FIFO back from it, channel select, error responses and a level interrupt.
module apb_sccb_cmd_regbank #(
   parameter int ADDR_W     = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int NUM_CH     = 2,
   parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] paddr_i,
   input  logic              psel_i,
   input  logic              penable_i,
   input  logic              pwrite_i,
   input  logic [31:0]       pwdata_i,
   output logic [31:0]       prdata_o,
   output logic              pready_o,
   output logic              pslverr_o,
   output logic              cmd_valid_o,
   input  logic              cmd_ready_i,
   output logic [31:0]       cmd_data_o,
   output logic [3:0]        cmd_wr_o,
   output logic [CH_W-1:0]   cmd_ch_o,
   input  logic              rsp_valid_i,
   input  logic [31:0]       rsp_data_i,
   input  logic              busy_i,
   output logic [15:0]       clk_div_o,
   output logic [15:0]       neg_del_o,
   output logic              irq_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam int EW = 4 + CH_W + 32;

   localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(8'h00);
   localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(8'h04);
   localparam logic [ADDR_W-1:0] A_CMD    = ADDR_W'(8'h08);
   localparam logic [ADDR_W-1:0] A_RSP    = ADDR_W'(8'h0C);
   localparam logic [ADDR_W-1:0] A_CMDWR  = ADDR_W'(8'h10);
   localparam logic [ADDR_W-1:0] A_CLKDIV = ADDR_W'(8'h14);
   localparam logic [ADDR_W-1:0] A_NEGDEL = ADDR_W'(8'h18);
   localparam logic [ADDR_W-1:0] A_IRQ    = ADDR_W'(8'h1C);

   logic              en_q, en_d, ien_q, ien_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [3:0]        wr_q, wr_d;
   logic [15:0]       div_q, div_d, neg_q, neg_d;
   logic [3:0]        irq_stat_q, irq_stat_d;
   logic              irq_q, irq_d;
   logic              busy_q;

   logic [EW-1:0]     cmd_mem_q [FIFO_DEPTH];
   logic [31:0]       rsp_mem_q [FIFO_DEPTH];
   logic [PW-1:0]     cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d;
   logic [PW-1:0]     rsp_wp_q, rsp_wp_d, rsp_rp_q, rsp_rp_d;

   logic              acc_s, wr_acc_s, rd_acc_s;
   logic [ADDR_W-1:0] addr_s;
   logic [PW-1:0]     cmd_level_s, rsp_level_s;
   logic              cmd_empty_s, cmd_full_s, rsp_empty_s, rsp_full_s;
   logic [EW-1:0]     cmd_head_s;
   logic [31:0]       rsp_head_s, status_s, ctrl_rd_s, rdata_s;
   logic              err_s;
   logic              sel_ctrl_s, sel_cmd_s, sel_rsp_s, sel_cmdwr_s;
   logic              sel_div_s, sel_neg_s, sel_irq_s;
   logic              flush_s, cmd_push_s, cmd_pop_s, cmd_ovf_s;
   logic              rsp_push_s, rsp_pop_s, rsp_ovf_s, rsp_unf_s, done_s;
   logic [3:0]        w1c_s, irq_set_s;

   assign acc_s    = psel_i & penable_i;
   assign wr_acc_s = acc_s & pwrite_i;
   assign rd_acc_s = acc_s & ~pwrite_i;
   assign addr_s   = paddr_i & ~ADDR_W'(2'b11);

   assign cmd_level_s = cmd_wp_q - cmd_rp_q;
   assign rsp_level_s = rsp_wp_q - rsp_rp_q;
   assign cmd_empty_s = (cmd_level_s == PW'(0));
   assign cmd_full_s  = (cmd_level_s == PW'(FIFO_DEPTH));
   assign rsp_empty_s = (rsp_level_s == PW'(0));
   assign rsp_full_s  = (rsp_level_s == PW'(FIFO_DEPTH));
   assign cmd_head_s  = cmd_mem_q[cmd_rp_q[AW-1:0]];
   assign rsp_head_s  = rsp_mem_q[rsp_rp_q[AW-1:0]];

   assign status_s = {9'd0, 7'(rsp_level_s), 1'b0, 7'(cmd_level_s), 4'd0,
                      rsp_empty_s, cmd_empty_s, cmd_full_s, busy_i};

   always_comb begin
      ctrl_rd_s             = 32'd0;
      ctrl_rd_s[0]          = en_q;
      ctrl_rd_s[1]          = ien_q;
      ctrl_rd_s[8 +: CH_W]  = ch_q;
   end

   // Address decode, read mux and error classification of the current APB address.
   always_comb begin
      sel_ctrl_s  = 1'b0;
      sel_cmd_s   = 1'b0;
      sel_rsp_s   = 1'b0;
      sel_cmdwr_s = 1'b0;
      sel_div_s   = 1'b0;
      sel_neg_s   = 1'b0;
      sel_irq_s   = 1'b0;
      rdata_s     = 32'd0;
      err_s       = 1'b0;
      case (addr_s)
         A_CTRL:   begin sel_ctrl_s = 1'b1; rdata_s = ctrl_rd_s; end
         A_STATUS: begin rdata_s = status_s; err_s = pwrite_i; end
         A_CMD:    begin sel_cmd_s = 1'b1; err_s = pwrite_i & cmd_full_s; end
         A_RSP: begin
            sel_rsp_s = 1'b1;
            err_s     = pwrite_i | rsp_empty_s;
            rdata_s   = (pwrite_i | rsp_empty_s) ? 32'd0 : rsp_head_s;
         end
         A_CMDWR:  begin sel_cmdwr_s = 1'b1; rdata_s = {28'd0, wr_q}; end
         A_CLKDIV: begin sel_div_s = 1'b1; rdata_s = {16'd0, div_q}; end
         A_NEGDEL: begin sel_neg_s = 1'b1; rdata_s = {16'd0, neg_q}; end
         A_IRQ:    begin sel_irq_s = 1'b1; rdata_s = {28'd0, irq_stat_q}; end
         default:  err_s = 1'b1;
      endcase
   end

   assign prdata_o  = psel_i ? rdata_s : 32'd0;
   assign pready_o  = acc_s;
   assign pslverr_o = acc_s & err_s;

   // Flush overrides every same-cycle FIFO movement; overflow on a full push is judged
   // against the current level, so a concurrent pop does not rescue it.
   assign flush_s    = wr_acc_s & sel_ctrl_s & pwdata_i[2];
   assign cmd_push_s = wr_acc_s & sel_cmd_s & ~cmd_full_s & ~flush_s;
   assign cmd_ovf_s  = wr_acc_s & sel_cmd_s & cmd_full_s;
   assign cmd_pop_s  = cmd_valid_o & cmd_ready_i & ~flush_s;
   assign rsp_push_s = rsp_valid_i & ~rsp_full_s & ~flush_s;
   assign rsp_ovf_s  = rsp_valid_i & rsp_full_s;
   assign rsp_pop_s  = rd_acc_s & sel_rsp_s & ~rsp_empty_s & ~flush_s;
   assign rsp_unf_s  = rd_acc_s & sel_rsp_s & rsp_empty_s;
   assign done_s     = busy_q & ~busy_i & cmd_empty_s;

   assign cmd_valid_o = en_q & ~cmd_empty_s;
   assign cmd_data_o  = cmd_head_s[31:0];
   assign cmd_ch_o    = cmd_head_s[32 +: CH_W];
   assign cmd_wr_o    = cmd_head_s[32 + CH_W +: 4];
   assign clk_div_o   = div_q;
   assign neg_del_o   = neg_q;
   assign irq_o       = irq_q;

   // Next-state values for configuration, status flags and FIFO pointers.
   always_comb begin
      en_d       = (wr_acc_s & sel_ctrl_s) ? pwdata_i[0] : en_q;
      ien_d      = (wr_acc_s & sel_ctrl_s) ? pwdata_i[1] : ien_q;
      ch_d       = (wr_acc_s & sel_ctrl_s) ? pwdata_i[8 +: CH_W] : ch_q;
      wr_d       = (wr_acc_s & sel_cmdwr_s) ? pwdata_i[3:0] : wr_q;
      div_d      = (wr_acc_s & sel_div_s) ? pwdata_i[15:0] : div_q;
      neg_d      = (wr_acc_s & sel_neg_s) ? pwdata_i[15:0] : neg_q;
      w1c_s      = (wr_acc_s & sel_irq_s) ? pwdata_i[3:0] : 4'd0;
      irq_set_s  = {rsp_unf_s, rsp_ovf_s, cmd_ovf_s, done_s};
      irq_stat_d = (irq_stat_q & ~w1c_s) | irq_set_s;
      irq_d      = ien_q & (|irq_stat_q);
      cmd_wp_d   = flush_s ? PW'(0) : cmd_wp_q + PW'(cmd_push_s);
      cmd_rp_d   = flush_s ? PW'(0) : cmd_rp_q + PW'(cmd_pop_s);
      rsp_wp_d   = flush_s ? PW'(0) : rsp_wp_q + PW'(rsp_push_s);
      rsp_rp_d   = flush_s ? PW'(0) : rsp_rp_q + PW'(rsp_pop_s);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         en_q       <= 1'b0;
         ien_q      <= 1'b0;
         ch_q       <= '0;
         wr_q       <= 4'd0;
         div_q      <= 16'd0;
         neg_q      <= 16'd0;
         irq_stat_q <= 4'd0;
         irq_q      <= 1'b0;
         busy_q     <= 1'b0;
         cmd_wp_q   <= '0;
         cmd_rp_q   <= '0;
         rsp_wp_q   <= '0;
         rsp_rp_q   <= '0;
      end else begin
         en_q       <= en_d;
         ien_q      <= ien_d;
         ch_q       <= ch_d;
         wr_q       <= wr_d;
         div_q      <= div_d;
         neg_q      <= neg_d;
         irq_stat_q <= irq_stat_d;
         irq_q      <= irq_d;
         busy_q     <= busy_i;
         cmd_wp_q   <= cmd_wp_d;
         cmd_rp_q   <= cmd_rp_d;
         rsp_wp_q   <= rsp_wp_d;
         rsp_rp_q   <= rsp_rp_d;
      end
   end

   // Storage is cleared on reset so the head outputs read zero afterwards.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            cmd_mem_q[i] <= '0;
            rsp_mem_q[i] <= 32'd0;
         end
      end else begin
         if (cmd_push_s) begin
            cmd_mem_q[cmd_wp_q[AW-1:0]] <= {wr_q, ch_q, pwdata_i};
         end
         if (rsp_push_s) begin
            rsp_mem_q[rsp_wp_q[AW-1:0]] <= rsp_data_i;
         end
      end
   end

endmodule

// File: tb/tb_apb_sccb_cmd_regbank.sv
// Directed/randomised bench for apb_sccb_cmd_regbank with a queue-based reference model.
module tb_apb_sccb_cmd_regbank;

   localparam int DEPTH = 8;

   typedef struct packed {
      logic [3:0]  w;
      logic        ch;
      logic [31:0] d;
   } cmd_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  paddr;
   logic        psel, penable, pwrite;
   logic [31:0] pwdata, prdata;
   logic        pready, pslverr;
   logic        cmd_valid, cmd_ready;
   logic [31:0] cmd_data;
   logic [3:0]  cmd_wr;
   logic [0:0]  cmd_ch;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        busy;
   logic [15:0] clk_div, neg_del;
   logic        irq;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit          m_en, m_ien, m_ch;
   logic [3:0]  m_wr, m_irq;
   logic [15:0] m_div, m_neg;
   cmd_t        cmdq[$];
   logic [31:0] rspq[$];

   always #5 clk = ~clk;

   apb_sccb_cmd_regbank dut (
      .clk_i(clk), .rst_i(rst),
      .paddr_i(paddr), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
      .pwdata_i(pwdata), .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
      .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_data_o(cmd_data),
      .cmd_wr_o(cmd_wr), .cmd_ch_o(cmd_ch),
      .rsp_valid_i(rsp_valid), .rsp_data_i(rsp_data), .busy_i(busy),
      .clk_div_o(clk_div), .neg_del_o(neg_del), .irq_o(irq)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic void m_reset();
      m_en = 1'b0; m_ien = 1'b0; m_ch = 1'b0;
      m_wr = 4'd0; m_irq = 4'd0; m_div = 16'd0; m_neg = 16'd0;
      cmdq.delete();
      rspq.delete();
   endfunction

   function automatic logic [31:0] m_status();
      logic [31:0] s;
      s = (32'(rspq.size()) << 16) | (32'(cmdq.size()) << 8) | 32'(busy);
      if (rspq.size() == 0) s = s | 32'h8;
      if (cmdq.size() == 0) s = s | 32'h4;
      if (cmdq.size() == DEPTH) s = s | 32'h2;
      return s;
   endfunction

   // Expected outcome of one APB access, applying its effects to the model.
   function automatic void mdl(input bit wr, input logic [7:0] a, input logic [31:0] d,
                               output logic [31:0] erd, output bit eerr);
      logic [7:0] aa;
      aa = a & 8'hFC;
      erd = 32'd0;
      eerr = 1'b0;
      case (aa)
         8'h00: if (wr) begin
                   m_en = d[0]; m_ien = d[1]; m_ch = d[8];
                   if (d[2]) begin cmdq.delete(); rspq.delete(); end
                end else erd = {23'd0, m_ch, 6'd0, m_ien, m_en};
         8'h04: if (wr) eerr = 1'b1; else erd = m_status();
         8'h08: if (wr) begin
                   if (cmdq.size() == DEPTH) begin eerr = 1'b1; m_irq[1] = 1'b1; end
                   else cmdq.push_back('{w: m_wr, ch: m_ch, d: d});
                end
         8'h0C: if (wr) eerr = 1'b1;
                else if (rspq.size() == 0) begin eerr = 1'b1; m_irq[3] = 1'b1; end
                else erd = rspq.pop_front();
         8'h10: if (wr) m_wr = d[3:0]; else erd = {28'd0, m_wr};
         8'h14: if (wr) m_div = d[15:0]; else erd = {16'd0, m_div};
         8'h18: if (wr) m_neg = d[15:0]; else erd = {16'd0, m_neg};
         8'h1C: if (wr) m_irq = m_irq & ~d[3:0]; else erd = {28'd0, m_irq};
         default: eerr = 1'b1;
      endcase
   endfunction

   task automatic apb(input bit wr, input logic [7:0] a, input logic [31:0] d, input string tag);
      logic [31:0] erd;
      bit eerr;
      mdl(wr, a, d, erd, eerr);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
      @(posedge clk); #1;
      penable = 1'b1;
      #4;
      chk({tag, "_pready"}, 32'(pready), 32'd1);
      chk({tag, "_pslverr"}, 32'(pslverr), 32'(eerr));
      if (!wr) chk({tag, "_prdata"}, prdata, erd);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic eng(input bit rdy, input string tag);
      bit ev;
      cmd_t h;
      cmd_ready = rdy;
      #4;
      ev = m_en && (cmdq.size() > 0);
      chk({tag, "_valid"}, 32'(cmd_valid), 32'(ev));
      if (ev) begin
         h = cmdq[0];
         chk({tag, "_data"}, cmd_data, h.d);
         chk({tag, "_wr"}, 32'(cmd_wr), 32'(h.w));
         chk({tag, "_ch"}, 32'(cmd_ch), 32'(h.ch));
      end
      @(posedge clk);
      if (ev && rdy) void'(cmdq.pop_front());
      #1;
      cmd_ready = 1'b0;
   endtask

   task automatic rpush(input logic [31:0] d);
      rsp_valid = 1'b1; rsp_data = d;
      @(posedge clk);
      if (rspq.size() < DEPTH) rspq.push_back(d); else m_irq[2] = 1'b1;
      #1;
      rsp_valid = 1'b0; rsp_data = 32'd0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded its time budget");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] erd;
      bit eerr;
      rst = 1'b1; paddr = 8'd0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = 32'd0;
      cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'd0; busy = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_pready", 32'(pready), 32'd0);
      chk("rst_pslverr", 32'(pslverr), 32'd0);
      chk("rst_prdata", prdata, 32'd0);
      chk("rst_clk_div", 32'(clk_div), 32'd0);
      chk("rst_neg_del", 32'(neg_del), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      apb(1'b0, 8'h04, 32'd0, "status_after_rst");

      // configuration and first command
      apb(1'b1, 8'h14, 32'h0000_0123, "wr_clkdiv");
      apb(1'b1, 8'h18, 32'h0000_0045, "wr_negdel");
      apb(1'b1, 8'h10, 32'h0000_0005, "wr_cmdwr");
      apb(1'b1, 8'h00, 32'h0000_0101, "wr_ctrl");
      chk("clk_div", 32'(clk_div), 32'h0123);
      chk("neg_del", 32'(neg_del), 32'h0045);
      apb(1'b0, 8'h00, 32'd0, "rd_ctrl");
      apb(1'b0, 8'h10, 32'd0, "rd_cmdwr");
      apb(1'b1, 8'h08, 32'hA5A5_0001, "push_first");
      #4;
      chk("first_data", cmd_data, 32'hA5A5_0001);
      chk("first_wr", 32'(cmd_wr), 32'd5);
      chk("first_ch", 32'(cmd_ch), 32'd1);
      #1;
      eng(1'b0, "first_hold");
      eng(1'b1, "first_pop");

      // overflow with engine stalled by enable=0
      apb(1'b1, 8'h00, 32'h0000_0000, "ctrl_disable");
      apb(1'b1, 8'h10, 32'($urandom_range(0, 15)), "wr_cmdwr_rand");
      cmd_ready = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) apb(1'b1, 8'h08, $urandom, "push_fill");
      chk("disabled_no_valid", 32'(cmd_valid), 32'd0);
      cmd_ready = 1'b0;
      apb(1'b0, 8'h1C, 32'd0, "irqstat_ovf");
      apb(1'b0, 8'h04, 32'd0, "status_full");
      apb(1'b1, 8'h00, 32'h0000_0002, "ctrl_irq_en");
      chk("irq_latency_0", 32'(irq), 32'd0);
      @(posedge clk); #1;
      chk("irq_latency_1", 32'(irq), 32'd1);
      apb(1'b1, 8'h1C, 32'h0000_0002, "w1c_ovf");
      apb(1'b0, 8'h1C, 32'd0, "irqstat_cleared");
      chk("irq_cleared", 32'(irq), 32'd0);

      // drain with toggling ready
      apb(1'b1, 8'h00, 32'h0000_0003, "ctrl_enable");
      for (int i = 0; i < 2 * DEPTH + 2; i++) eng(i[0], "drain");
      busy = 1'b1;
      apb(1'b0, 8'h04, 32'd0, "status_busy");
      busy = 1'b0;
      @(posedge clk);
      m_irq[0] = 1'b1;
      #1;
      apb(1'b0, 8'h1C, 32'd0, "irqstat_done");
      chk("irq_done", 32'(irq), 32'd1);
      apb(1'b1, 8'h1C, 32'h0000_0001, "w1c_done");

      // response FIFO
      rpush(32'h0000_0011);
      rpush(32'h0000_0022);
      for (int i = 0; i < 3; i++) apb(1'b0, 8'h0C, 32'd0, "rsp_read");
      apb(1'b0, 8'h1C, 32'd0, "irqstat_unf");
      apb(1'b1, 8'h1C, 32'h0000_000F, "w1c_all");
      for (int i = 0; i < DEPTH + 1; i++) rpush($urandom);
      apb(1'b0, 8'h04, 32'd0, "status_rsp_full");
      apb(1'b0, 8'h1C, 32'd0, "irqstat_rsp_ovf");
      for (int i = 0; i < DEPTH; i++) apb(1'b0, 8'h0C, 32'd0, "rsp_drain");
      apb(1'b1, 8'h1C, 32'h0000_000F, "w1c_all2");

      // error responses
      apb(1'b0, 8'h20, 32'd0, "unmapped_rd");
      apb(1'b1, 8'h04, 32'hFFFF_FFFF, "wr_status");
      apb(1'b1, 8'h0C, 32'h1234_5678, "wr_rspdata");
      apb(1'b0, 8'h1E, 32'd0, "rd_irq_lowbits");

      // flush with queued traffic and a same-cycle engine response
      apb(1'b1, 8'h00, 32'h0000_0002, "ctrl_hold");
      for (int i = 0; i < 3; i++) apb(1'b1, 8'h08, $urandom, "push_pre_flush");
      rpush($urandom);
      rpush($urandom);
      mdl(1'b1, 8'h00, 32'h0000_0006, erd, eerr);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'h0000_0006;
      @(posedge clk); #1;
      penable = 1'b1; rsp_valid = 1'b1; rsp_data = $urandom;
      #4;
      chk("flush_pslverr", 32'(pslverr), 32'(eerr));
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rsp_valid = 1'b0;
      apb(1'b0, 8'h04, 32'd0, "status_flushed");
      apb(1'b0, 8'h00, 32'd0, "ctrl_flush_reads0");
      apb(1'b1, 8'h00, 32'h0000_0003, "ctrl_enable2");
      chk("flushed_no_valid", 32'(cmd_valid), 32'd0);

      // reset in the middle of traffic
      apb(1'b1, 8'h00, 32'h0000_0103, "ctrl_pre_rst");
      apb(1'b1, 8'h08, $urandom, "push_pre_rst");
      apb(1'b1, 8'h08, $urandom, "push_pre_rst");
      apb(1'b0, 8'h0C, 32'd0, "unf_pre_rst");
      @(posedge clk); #1;
      chk("pre_rst_valid", 32'(cmd_valid), 32'd1);
      chk("pre_rst_irq", 32'(irq), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_cmd_valid", 32'(cmd_valid), 32'd0);
      chk("midrst_irq", 32'(irq), 32'd0);
      chk("midrst_cmd_data", cmd_data, 32'd0);
      chk("midrst_clk_div", 32'(clk_div), 32'd0);
      m_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      apb(1'b0, 8'h04, 32'd0, "status_post_rst");
      apb(1'b0, 8'h00, 32'd0, "ctrl_post_rst");
      apb(1'b0, 8'h1C, 32'd0, "irq_post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
